// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers; optional source tag via `ARB_SRC_TAG_EN.
// Latency: one ARB bubble per grant, then up to MAX_BURST words back-to-back (first word 1 cycle after req seen).
// Backpressure: full=1 drops req_ready/wr and freezes the burst count; the grant is held through the stall.
module fifo_wr_arbiter #(
   parameter int  NUM_REQ    = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  MAX_BURST  = 4,
   localparam int ID_WIDTH   = $clog2(NUM_REQ),
   localparam int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_req_ready,
   input  logic                          i_full,
   output logic                          o_wr,
`ifdef ARB_SRC_TAG_EN
   output logic [DATA_WIDTH+ID_WIDTH-1:0] o_wr_data,
`else
   output logic [DATA_WIDTH-1:0]          o_wr_data,
`endif
   output logic                          o_busy,
   output logic [ID_WIDTH-1:0]           o_owner
);

   localparam logic ST_ARB   = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   logic                  r_state;
   logic [ID_WIDTH-1:0]   r_rr_ptr;
   logic [ID_WIDTH-1:0]   r_owner;
   logic [CNT_WIDTH-1:0]  r_burst_cnt;

   logic                  w_found;
   logic [ID_WIDTH-1:0]   w_winner;
   logic                  w_grant_open;
   logic                  w_xfer;
   logic                  w_last_word;
   logic                  w_release;
   logic [ID_WIDTH-1:0]   w_next_ptr;
   logic [DATA_WIDTH-1:0] w_sel_data;

   // Reset masks every output strobe combinationally so the in-flight cycle never writes.
   assign w_grant_open = !i_rst && (r_state == ST_GRANT) && !i_full;
   assign w_xfer       = w_grant_open && i_req[r_owner];
   assign w_last_word  = (r_burst_cnt + 1'b1) == CNT_WIDTH'(MAX_BURST);
   // A dropped request releases even while full; a stall with req held does not.
   assign w_release    = !i_req[r_owner] || (w_xfer && w_last_word);
   assign w_next_ptr   = (r_owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
   assign w_sel_data   = i_req_data[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];

   assign o_wr    = w_xfer;
   assign o_busy  = !i_rst && (r_state == ST_GRANT);
   assign o_owner = r_owner;

`ifdef ARB_SRC_TAG_EN
   assign o_wr_data = {r_owner, w_sel_data};
`else
   assign o_wr_data = w_sel_data;
`endif

   // Scan requests starting at rr_ptr, wrapping modulo NUM_REQ; first set bit wins.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && i_req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
            w_found  = 1'b1;
            w_winner = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Only the current owner sees ready, and only while the FIFO has room.
   always_comb begin
      o_req_ready = '0;
      if (w_grant_open) begin
         o_req_ready[r_owner] = 1'b1;
      end
   end

   // Arbitration FSM: ARB picks a winner, GRANT streams its burst until release.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_ARB;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_burst_cnt <= '0;
      end else if (r_state == ST_ARB) begin
         if (w_found) begin
            r_owner     <= w_winner;
            r_burst_cnt <= '0;
            r_state     <= ST_GRANT;
         end
      end else begin
         if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
         end
         if (w_release) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= w_next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a scoreboard of expected FIFO writes.
// Latency: stimulus changes 1 time unit after posedge, outputs are sampled on negedge.
// Backpressure: full is driven directly to exercise mid-burst stalls.
module tb_fifo_wr_arbiter;

`ifdef ARB_SRC_TAG_EN
   localparam int WD_W = 10;
`else
   localparam int WD_W = 8;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [31:0]     req_data;
   logic [3:0]      req_ready;
   logic            full;
   logic            wr;
   logic [WD_W-1:0] wr_data;
   logic            busy;
   logic [1:0]      owner;

   int checks = 0;
   int passes = 0;
   int wr_seen = 0;
   logic [31:0] sb_data[$];
   logic [1:0]  sb_own[$];

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
      .o_req_ready(req_ready), .i_full(full), .o_wr(wr), .o_wr_data(wr_data),
      .o_busy(busy), .o_owner(owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_word(input logic [1:0] o);
      logic [7:0] d;
      d = req_data[int'(o)*8 +: 8];
`ifdef ARB_SRC_TAG_EN
      return {22'b0, o, d};
`else
      return {24'b0, d};
`endif
   endfunction

   task automatic push_burst(input logic [1:0] o, input int n);
      for (int i = 0; i < n; i++) begin
         sb_data.push_back(exp_word(o));
         sb_own.push_back(o);
      end
   endtask

   task automatic expect_cycle(input string tag, input logic e_wr, input logic e_busy,
                               input logic [1:0] e_own, input logic [3:0] e_rdy);
      @(negedge clk);
      check({tag, "_wr"}, {31'b0, wr}, {31'b0, e_wr});
      check({tag, "_busy"}, {31'b0, busy}, {31'b0, e_busy});
      check({tag, "_owner"}, {30'b0, owner}, {30'b0, e_own});
      check({tag, "_ready"}, {28'b0, req_ready}, {28'b0, e_rdy});
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every FIFO write pops the oldest expected word and owner.
   always @(negedge clk) begin
      if (wr === 1'b1) begin
         wr_seen++;
         if (sb_data.size() == 0) begin
            checks++;
            assert (sb_data.size() != 0) passes++;
            else $error("FAIL sb_underflow observed=%0h expected=no_write", wr_data);
         end else begin
            check("sb_data", 32'(wr_data), sb_data.pop_front());
            check("sb_owner", {30'b0, owner}, {30'b0, sb_own.pop_front()});
         end
      end
   end

   initial begin
      rst      = 1'b1;
      req      = 4'b1111;
      full     = 1'b0;
      req_data = {8'hA5, 8'hC2, 8'hB1, 8'hA0};

      // Reset held two cycles with all requests up.
      expect_cycle("rst0", 1'b0, 1'b0, 2'd0, 4'b0000);
      expect_cycle("rst1", 1'b0, 1'b0, 2'd0, 4'b0000);

      // Lone requester 2: full burst, bubble, then reset lands mid-burst.
      rst = 1'b0;
      req = 4'b0100;
      push_burst(2'd2, 6);
      expect_cycle("single_arb0", 1'b0, 1'b0, 2'd0, 4'b0000);
      repeat (4) expect_cycle("single_w", 1'b1, 1'b1, 2'd2, 4'b0100);
      expect_cycle("single_arb1", 1'b0, 1'b0, 2'd2, 4'b0000);
      repeat (2) expect_cycle("single_w2", 1'b1, 1'b1, 2'd2, 4'b0100);
      rst = 1'b1;
      expect_cycle("rst_mid", 1'b0, 1'b0, 2'd2, 4'b0000);

      // All requesters: order 0,1,2,3,0 from rr_ptr=0, 4 writes per 5 cycles.
      rst     = 1'b0;
      req     = 4'b1111;
      wr_seen = 0;
      for (int b = 0; b < 5; b++) begin
         push_burst(2'(b % 4), 4);
         expect_cycle("rr_arb", 1'b0, 1'b0, (b == 0) ? 2'd0 : 2'((b - 1) % 4), 4'b0000);
         repeat (4) expect_cycle("rr_w", 1'b1, 1'b1, 2'(b % 4), 4'b0001 << (b % 4));
      end
      check("rr_duty", wr_seen, 20);

      // Early release: owner 1 drops after 2 words; next pick starts at rr_ptr=2.
      req = 4'b0110;
      push_burst(2'd1, 2);
      expect_cycle("er_arb", 1'b0, 1'b0, 2'd0, 4'b0000);
      repeat (2) expect_cycle("er_w", 1'b1, 1'b1, 2'd1, 4'b0010);
      req = 4'b0101;
      expect_cycle("er_drop", 1'b0, 1'b1, 2'd1, 4'b0010);
      push_burst(2'd2, 4);
      expect_cycle("er_arb2", 1'b0, 1'b0, 2'd1, 4'b0000);

      // Full stall after 2 words: grant held, exactly 2 more words afterwards.
      repeat (2) expect_cycle("fs_w", 1'b1, 1'b1, 2'd2, 4'b0100);
      full = 1'b1;
      repeat (3) expect_cycle("fs_stall", 1'b0, 1'b1, 2'd2, 4'b0000);
      full = 1'b0;
      repeat (2) expect_cycle("fs_w2", 1'b1, 1'b1, 2'd2, 4'b0100);
      req = 4'b1000;
      push_burst(2'd3, 4);
      expect_cycle("fs_arb", 1'b0, 1'b0, 2'd2, 4'b0000);

      // Requester 3 payload 8'hA5, tagged with its ID when the tag build is used.
      @(negedge clk);
      check("tag_wr", {31'b0, wr}, 32'd1);
`ifdef ARB_SRC_TAG_EN
      check("tag_data", 32'(wr_data), 32'h3A5);
`else
      check("tag_data", 32'(wr_data), 32'hA5);
`endif
      @(posedge clk);
      #1;
      repeat (3) expect_cycle("tag_w", 1'b1, 1'b1, 2'd3, 4'b1000);
      req = 4'b0000;
      repeat (3) expect_cycle("idle", 1'b0, 1'b0, 2'd3, 4'b0000);
      check("sb_drain", sb_data.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
